// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the byte-wide memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic [31:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        rd0, rd1;
    logic        wr0, wr1;
    logic        ready0, ready1;
    logic [7:0]  rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, rd0, rd1, wr0, wr1,
        input  mem_rdata, mem_ready,
        output gnt0, gnt1, ready0, ready1, rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, rd0, rd1, wr0, wr1,
        output mem_rdata, mem_ready,
        input  gnt0, gnt1, ready0, ready1, rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (0 = wasm loader, 1 = CPU) for a shared byte-wide memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaks; otherwise requester 0 wins ties.
module mem_arbiter #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, HANDOVER} state_t;

    localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);
    localparam logic        PREEMPT_EN = (MAX_HOLD != 0);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;
`endif

    logic tie_winner;
    logic pend_any, pend_sel;
    logic owner_req, other_req, owner_busy, preempt;

    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_winner = ~last_q;
`else
        tie_winner = 1'b0;
`endif
        pend_any = bus.req0 | bus.req1;
        pend_sel = (bus.req0 & bus.req1) ? tie_winner : bus.req1;

        owner_req  = 1'b0;
        other_req  = 1'b0;
        owner_busy = 1'b0;
        if (state_q == OWN0) begin
            owner_req  = bus.req0;
            other_req  = bus.req1;
            owner_busy = bus.rd0 | bus.wr0 | bus.mem_ready;
        end else if (state_q == OWN1) begin
            owner_req  = bus.req1;
            other_req  = bus.req0;
            owner_busy = bus.rd1 | bus.wr1 | bus.mem_ready;
        end
        // A busy owner is never cut off mid-access, whatever the hold count says.
        preempt = PREEMPT_EN && (hold_q >= HOLD_LIMIT) && other_req && !owner_busy;

        state_d = state_q;
        hold_d  = hold_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pend_any) begin
                    state_d = pend_sel ? OWN1 : OWN0;
                end
            end
            OWN0, OWN1: begin
                if (other_req && (hold_q != 16'hFFFF)) begin
                    hold_d = hold_q + 16'd1;
                end
                if (!owner_req || preempt) begin
                    state_d = HANDOVER;
                end
            end
            HANDOVER: begin
                if (!bus.mem_ready) begin
                    if (pend_any) begin
                        state_d = pend_sel ? OWN1 : OWN0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == OWN0 || state_d == OWN1) && state_d != state_q) begin
            hold_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d = (state_d == OWN1);
`endif
        end

        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Memory side follows the registered owner with no added latency.
    always_comb begin
        bus.gnt0      = gnt0_q;
        bus.gnt1      = gnt1_q;
        bus.ready0    = gnt0_q & bus.mem_ready;
        bus.ready1    = gnt1_q & bus.mem_ready;
        bus.rdata     = bus.mem_rdata;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        if (gnt0_q) begin
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
            bus.mem_rd    = bus.rd0;
            bus.mem_wr    = bus.wr0;
        end else if (gnt1_q) begin
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
            bus.mem_rd    = bus.rd1;
            bus.mem_wr    = bus.wr1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed cycle-exact scenarios plus randomized traffic,
// all checked every cycle against a behavioural ownership model.
module tb_mem_arbiter;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: who owns the bus (-1 = nobody), whether we are in the dead gap,
    // how long the other side has waited, and who was granted last.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_wait  = 0;
    int m_last  = 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int pick_next();
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (bus.req0) return 0;
        if (bus.req1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int pick;
        bit mine, other, busy;
        if (rst) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_wait  = 0;
            m_last  = 1;
        end else if (m_gap || m_owner < 0) begin
            if (!(m_gap && bus.mem_ready)) begin
                m_gap = 1'b0;
                pick  = pick_next();
                if (pick >= 0) begin
                    m_owner = pick;
                    m_wait  = 0;
                    m_last  = pick;
                end
            end
        end else begin
            mine  = (m_owner == 0) ? bus.req0 : bus.req1;
            other = (m_owner == 0) ? bus.req1 : bus.req0;
            busy  = bus.mem_ready | ((m_owner == 0) ? (bus.rd0 | bus.wr0) : (bus.rd1 | bus.wr1));
            if (!mine || (MAX_HOLD != 0 && m_wait >= MAX_HOLD && other && !busy)) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (other && m_wait < 65535) begin
                m_wait++;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_rd, e_wr;
        e_addr  = '0;
        e_wdata = '0;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
        if (m_owner == 0) begin
            e_addr = bus.addr0; e_wdata = bus.wdata0; e_rd = bus.rd0; e_wr = bus.wr0;
        end else if (m_owner == 1) begin
            e_addr = bus.addr1; e_wdata = bus.wdata1; e_rd = bus.rd1; e_wr = bus.wr1;
        end
        checkOutput("model gnt0", 32'(bus.gnt0), 32'(m_owner == 0));
        checkOutput("model gnt1", 32'(bus.gnt1), 32'(m_owner == 1));
        checkOutput("model ready0", 32'(bus.ready0), 32'((m_owner == 0) && bus.mem_ready));
        checkOutput("model ready1", 32'(bus.ready1), 32'((m_owner == 1) && bus.mem_ready));
        checkOutput("model mem_addr", bus.mem_addr, e_addr);
        checkOutput("model mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        checkOutput("model mem_rd", 32'(bus.mem_rd), 32'(e_rd));
        checkOutput("model mem_wr", 32'(bus.mem_wr), 32'(e_wr));
        checkOutput("model rdata", 32'(bus.rdata), 32'(bus.mem_rdata));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        if ($urandom_range(9) == 0) bus.req0 = ~bus.req0;
        if ($urandom_range(9) == 0) bus.req1 = ~bus.req1;
        bus.addr0     = $urandom;
        bus.addr1     = $urandom;
        bus.wdata0    = 8'($urandom);
        bus.wdata1    = 8'($urandom);
        bus.rd0       = ($urandom_range(3) == 0);
        bus.rd1       = ($urandom_range(3) == 0);
        bus.wr0       = ($urandom_range(3) == 0);
        bus.wr1       = ($urandom_range(3) == 0);
        bus.mem_ready = ($urandom_range(3) == 0);
        bus.mem_rdata = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 1;
        bus.addr0 = '0; bus.addr1 = 32'h10;
        bus.wdata0 = '0; bus.wdata1 = '0;
        bus.rd0 = 0; bus.rd1 = 1; bus.wr0 = 0; bus.wr1 = 0;
        bus.mem_rdata = 8'h00; bus.mem_ready = 1;

        // Reset state: no owner, so memory_ready is not forwarded
        repeat (3) @(negedge clk);
        checkOutput("reset gnt0", 32'(bus.gnt0), 0);
        checkOutput("reset gnt1", 32'(bus.gnt1), 0);
        checkOutput("reset ready1", 32'(bus.ready1), 0);
        checkOutput("reset mem_addr", bus.mem_addr, 0);
        checkOutput("reset mem_rd", 32'(bus.mem_rd), 0);

        step(); rst = 1'b0; bus.mem_ready = 0;                         // c0
        @(negedge clk);
        checkOutput("c0 gnt1", 32'(bus.gnt1), 0);

        step(); bus.mem_ready = 1; bus.mem_rdata = 8'h41;              // c1
        @(negedge clk);
        checkOutput("single gnt1", 32'(bus.gnt1), 1);
        checkOutput("single mem_addr", bus.mem_addr, 32'h10);
        checkOutput("single mem_rd", 32'(bus.mem_rd), 1);
        checkOutput("single ready1", 32'(bus.ready1), 1);
        checkOutput("single rdata", 32'(bus.rdata), 32'h41);
        checkOutput("single ready0", 32'(bus.ready0), 0);

        step(); bus.mem_ready = 0; bus.rd1 = 0; bus.req1 = 0;          // c2
        @(negedge clk);
        checkOutput("c2 gnt1 held", 32'(bus.gnt1), 1);

        step();                                                       // c3
        @(negedge clk);
        checkOutput("release gnt1", 32'(bus.gnt1), 0);

        step(); bus.req0 = 1; bus.req1 = 1; bus.wr0 = 1;               // c4
        bus.addr0 = 32'h20; bus.wdata0 = 8'h5A;
        @(negedge clk);
        checkOutput("idle gnt0", 32'(bus.gnt0), 0);
        checkOutput("idle mem_wr", 32'(bus.mem_wr), 0);

        step(); bus.wr0 = 0; bus.req0 = 0;                             // c5
        @(negedge clk);
        checkOutput("tie gnt0", 32'(bus.gnt0), 1);
        checkOutput("tie gnt1", 32'(bus.gnt1), 0);

        step();                                                       // c6
        @(negedge clk);
        checkOutput("tie gap gnt0", 32'(bus.gnt0), 0);
        checkOutput("tie gap gnt1", 32'(bus.gnt1), 0);

        step(); bus.req0 = 1;                                         // c7
        @(negedge clk);
        checkOutput("tie then gnt1", 32'(bus.gnt1), 1);

        repeat (4) step();                                            // c8..c11
        @(negedge clk);
        checkOutput("hold gnt1", 32'(bus.gnt1), 1);
        step();                                                       // c12
        @(negedge clk);
        checkOutput("preempt gnt1", 32'(bus.gnt1), 0);
        checkOutput("preempt gnt0", 32'(bus.gnt0), 0);
        step(); bus.rd0 = 1;                                          // c13
        @(negedge clk);
        checkOutput("preempt regrant gnt0", 32'(bus.gnt0), 1);

        repeat (5) step();                                            // c14..c18
        @(negedge clk);
        checkOutput("read blocks preempt", 32'(bus.gnt0), 1);
        step(); bus.mem_ready = 1;                                    // c19
        @(negedge clk);
        checkOutput("read done gnt0", 32'(bus.gnt0), 1);
        checkOutput("read done ready0", 32'(bus.ready0), 1);
        step(); bus.rd0 = 0; bus.mem_ready = 0;                       // c20
        @(negedge clk);
        checkOutput("ready blocks preempt", 32'(bus.gnt0), 1);
        step(); bus.req0 = 0;                                         // c21
        @(negedge clk);
        checkOutput("late preempt gnt0", 32'(bus.gnt0), 0);

        step(); bus.req0 = 1; bus.req1 = 0; bus.mem_ready = 1;         // c22
        @(negedge clk);
        checkOutput("after preempt gnt1", 32'(bus.gnt1), 1);
        for (int i = 0; i < 3; i++) begin                             // c23..c25
            step();
            bus.rd0 = 1;
            bus.mem_ready = (i < 2);
            @(negedge clk);
            checkOutput("stretch gnt0", 32'(bus.gnt0), 0);
            checkOutput("stretch gnt1", 32'(bus.gnt1), 0);
            checkOutput("stretch mem_rd", 32'(bus.mem_rd), 0);
        end
        step(); bus.rd0 = 0; bus.wr0 = 1; bus.mem_ready = 1;           // c26
        @(negedge clk);
        checkOutput("stretch end gnt0", 32'(bus.gnt0), 1);

        step(); #1;
        checkOutput("pre-reset mem_wr", 32'(bus.mem_wr), 1);
        checkOutput("pre-reset ready0", 32'(bus.ready0), 1);
        rst = 1'b1;
        #1;
        checkOutput("async gnt0", 32'(bus.gnt0), 0);
        checkOutput("async mem_wr", 32'(bus.mem_wr), 0);
        checkOutput("async ready0", 32'(bus.ready0), 0);
        bus.req0 = 0; bus.req1 = 1; bus.wr0 = 0; bus.mem_ready = 0;
        step(); rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset gnt1 low", 32'(bus.gnt1), 0);
        step();
        @(negedge clk);
        checkOutput("post-reset gnt1", 32'(bus.gnt1), 1);

        for (int n = 0; n < 3000; n++) begin
            step();
            applyStimulus();
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
